fibonacci_top: RTL and testbench

//  Board-level UART Fibonacci calculator. The host sends index N as one UART byte.
//  The block computes F(N) as an unsigned 32-bit value and returns it as 4 bytes,
//  LSB first. Switches select which result nibble is shown on the LEDs.

---
 rtl/fibonacci_pkg.sv | 33 +++
 rtl/fibonacci_uart_8n1.sv | 136 +++++++++++++
 rtl/fibonacci_top.sv | 174 +++++++++++++++++
 tb/tb_fibonacci_top.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fibonacci_pkg.sv
// Shared definitions for the UART Fibonacci calculator.
//   FIB_W      result width
//   FIB_MAX_N  largest index whose Fibonacci number fits in FIB_W bits
//   FIB_SAT    value returned for indices above FIB_MAX_N
//   fib_state_t  top-level control states
//   rx_state_t   UART receiver states
//   nibble_sel   picks nibble 'sel' out of a result word
package fibonacci_pkg;

    localparam int unsigned      FIB_W     = 32;
    localparam int unsigned      FIB_MAX_N = 47;
    localparam logic [FIB_W-1:0] FIB_SAT   = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_SEND
    } fib_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    function automatic logic [3:0] nibble_sel(input logic [FIB_W-1:0] value,
                                              input logic [2:0]       sel);
        return value[{sel, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/fibonacci_uart_8n1.sv
// 8N1 UART, receive and transmit, BIT_CLKS clocks per bit.
//   clk, rst_n   clock and active-low reset (asynchronous assert)
//   rx           receive line, already synchronized to clk, idle high
//   rx_byte      last received byte, valid while rx_valid is high
//   rx_valid     one-cycle strobe for a correctly framed byte
//   tx_byte      byte to transmit, sampled when tx_start is accepted
//   tx_start     request to transmit; accepted only while tx_busy is low
//   tx_busy      high from accepted start until the stop bit has completed
//   tx           transmit line, idle high
module uart_8n1 #(
    parameter int unsigned BIT_CLKS = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    input  logic [7:0] tx_byte,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx
);
    import fibonacci_pkg::*;

    localparam int unsigned     CW       = (BIT_CLKS > 2) ? $clog2(BIT_CLKS) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(BIT_CLKS - 1);
    localparam logic [CW-1:0]   CNT_HALF = CW'(BIT_CLKS / 2 - 1);

    // ---------------- receiver ----------------
    rx_state_t     rx_state;
    rx_state_t     rx_next;
    logic          rx_prev;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= RX_IDLE;
        end else begin
            rx_state <= rx_next;
        end
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:
                if (rx_prev && !rx) rx_next = RX_START;
            RX_START:
                // a start bit that is high again at mid-bit was a glitch
                if (rx_cnt == CNT_HALF) rx_next = rx ? RX_IDLE : RX_DATA;
            RX_DATA:
                if (rx_cnt == CNT_LAST && rx_bit == 3'd7) rx_next = RX_STOP;
            RX_STOP:
                if (rx_cnt == CNT_LAST) rx_next = rx ? RX_IDLE : RX_WAIT_HIGH;
            RX_WAIT_HIGH:
                if (rx) rx_next = RX_IDLE;
            default:
                rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_prev  <= 1'b1;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_sh    <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_prev  <= rx;
            rx_valid <= 1'b0;

            // counter restarts on every state change, so the START->DATA
            // transition at half a bit puts later samples at mid-bit
            if (rx_next != rx_state || rx_state == RX_IDLE ||
                rx_state == RX_WAIT_HIGH || rx_cnt == CNT_LAST) begin
                rx_cnt <= '0;
            end else begin
                rx_cnt <= rx_cnt + 1'b1;
            end

            if (rx_state == RX_START) begin
                rx_bit <= '0;
            end

            if (rx_state == RX_DATA && rx_cnt == CNT_LAST) begin
                rx_sh  <= {rx, rx_sh[7:1]};
                rx_bit <= rx_bit + 1'b1;
            end

            if (rx_state == RX_STOP && rx_cnt == CNT_LAST && rx) begin
                rx_valid <= 1'b1;
            end
        end
    end

    assign rx_byte = rx_sh;

    // ---------------- transmitter ----------------
    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_bit;
    logic [8:0]    tx_sh;

    // tx_bit 0 is the start bit, 1..8 data, 9 the stop bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx      <= 1'b1;
            tx_busy <= 1'b0;
            tx_sh   <= '1;
            tx_cnt  <= '0;
            tx_bit  <= '0;
        end else if (!tx_busy) begin
            if (tx_start) begin
                tx      <= 1'b0;
                tx_sh   <= {1'b1, tx_byte};
                tx_busy <= 1'b1;
                tx_cnt  <= '0;
                tx_bit  <= '0;
            end
        end else if (tx_cnt == CNT_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == 4'd9) begin
                tx_busy <= 1'b0;
            end else begin
                tx     <= tx_sh[0];
                tx_sh  <= {1'b1, tx_sh[8:1]};
                tx_bit <= tx_bit + 1'b1;
            end
        end else begin
            tx_cnt <= tx_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fibonacci_top.sv
// Board-level UART Fibonacci calculator.
// Receives index N as one UART byte, computes F(N) (saturating to all ones
// above N=47) and returns it as four bytes, LSB first.
//   clk          system clock
//   nRst         asynchronous active-low reset
//   rx           UART receive line, idle high
//   sw2..sw0     select which result nibble drives led3..led0
//   tx           UART transmit line, idle high
//   led4         busy: request accepted and reply not yet fully sent
//   led3..led0   selected nibble of the last result
module fibonacci_top #(
    parameter int unsigned CLK_HZ   = 50_000_000,
    parameter int unsigned BAUD     = 115_200,
    parameter int unsigned BIT_CLKS = CLK_HZ / BAUD
) (
    input  logic clk,
    input  logic nRst,
    input  logic rx,
    input  logic sw2,
    input  logic sw1,
    input  logic sw0,
    output logic tx,
    output logic led4,
    output logic led3,
    output logic led2,
    output logic led1,
    output logic led0
);
    import fibonacci_pkg::*;

    // ---------------- reset and input synchronizers ----------------
    logic [1:0] rst_pipe;
    logic       rst_n;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            rst_pipe <= '0;
        end else begin
            rst_pipe <= {rst_pipe[0], 1'b1};
        end
    end

    assign rst_n = rst_pipe[1];

    logic       rx_meta;
    logic       rx_sync;
    logic [2:0] sw_meta;
    logic [2:0] sw_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            sw_meta <= {sw2, sw1, sw0};
            sw_sync <= sw_meta;
        end
    end

    // ---------------- UART ----------------
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic [7:0] tx_byte;
    logic       tx_start;
    logic       tx_busy;

    uart_8n1 #(
        .BIT_CLKS(BIT_CLKS)
    ) u_uart (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx_sync),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .tx_byte  (tx_byte),
        .tx_start (tx_start),
        .tx_busy  (tx_busy),
        .tx       (tx)
    );

    // ---------------- control FSM ----------------
    fib_state_t       state;
    fib_state_t       state_next;
    logic [7:0]       n_reg;
    logic [5:0]       iter;
    logic [FIB_W-1:0] a;
    logic [FIB_W-1:0] b;
    logic [FIB_W-1:0] result;
    logic [2:0]       sent;
    logic             saturate;
    logic             calc_done;

    assign saturate  = (n_reg > 8'(FIB_MAX_N));
    assign calc_done = saturate || (iter == n_reg[5:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        tx_start   = 1'b0;
        case (state)
            ST_IDLE:
                if (rx_valid) state_next = ST_CALC;
            ST_CALC:
                if (calc_done) state_next = ST_SEND;
            ST_SEND:
                if (sent != 3'd4) begin
                    tx_start = !tx_busy;
                end else if (!tx_busy) begin
                    state_next = ST_IDLE;
                end
            default:
                state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_reg  <= '0;
            iter   <= '0;
            a      <= '0;
            b      <= '0;
            result <= '0;
            sent   <= '0;
        end else begin
            case (state)
                ST_IDLE:
                    if (rx_valid) begin
                        n_reg <= rx_byte;
                        iter  <= '0;
                        a     <= '0;
                        b     <= {{(FIB_W-1){1'b0}}, 1'b1};
                        sent  <= '0;
                    end
                ST_CALC:
                    // b may wrap on the last step for N=47; only a is kept
                    if (calc_done) begin
                        result <= saturate ? FIB_SAT : a;
                    end else begin
                        a    <= b;
                        b    <= a + b;
                        iter <= iter + 1'b1;
                    end
                ST_SEND:
                    if (tx_start) sent <= sent + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        case (sent[1:0])
            2'd0:    tx_byte = result[7:0];
            2'd1:    tx_byte = result[15:8];
            2'd2:    tx_byte = result[23:16];
            default: tx_byte = result[31:24];
        endcase
    end

    // ---------------- LEDs ----------------
    assign led4 = (state != ST_IDLE);
    assign {led3, led2, led1, led0} = nibble_sel(result, sw_sync);

endmodule

// File: tb/tb_fibonacci_top.sv
// Self-checking bench for fibonacci_top, run with a short bit time.
module tb_fibonacci_top;

    localparam int unsigned BIT = 16;  // 50 MHz / 3.125 Mbaud

    logic clk;
    logic nRst;
    logic rx;
    logic sw2, sw1, sw0;
    logic tx;
    logic led4, led3, led2, led1, led0;
    logic [3:0] led_nib;

    assign led_nib = {led3, led2, led1, led0};

    fibonacci_top #(
        .CLK_HZ(50_000_000),
        .BAUD  (3_125_000)
    ) dut (
        .clk  (clk),
        .nRst (nRst),
        .rx   (rx),
        .sw2  (sw2),
        .sw1  (sw1),
        .sw0  (sw0),
        .tx   (tx),
        .led4 (led4),
        .led3 (led3),
        .led2 (led2),
        .led1 (led1),
        .led0 (led0)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    logic [7:0]  exp_q[$];
    logic [31:0] model_result = '0;
    logic        chk_en = 1'b0;
    logic        mon_discard = 1'b0;
    int          bytes_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: F(n) by plain 64-bit iteration, saturated when it exceeds 32 bits
    function automatic logic [31:0] fib_model(input int unsigned n);
        longint unsigned x = 0;
        longint unsigned y = 1;
        longint unsigned t;
        for (int unsigned i = 0; i < n; i++) begin
            t = x + y;
            x = y;
            y = t;
        end
        if (x > 64'hFFFF_FFFF) return 32'hFFFF_FFFF;
        return x[31:0];
    endfunction

    // TX line decoder: every decoded byte is compared with the expected queue
    initial begin
        logic [7:0] got;
        logic       stop;
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                repeat (BIT / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT) @(negedge clk);
                    got[i] = tx;
                end
                repeat (BIT) @(negedge clk);
                stop = tx;
                if (!mon_discard) begin
                    check("tx_stop_bit", {31'b0, stop}, 32'd1);
                    if (exp_q.size() == 0) begin
                        check("tx_unexpected_byte", {24'b0, got}, 32'hFFFF_FFFF);
                    end else begin
                        check("tx_byte", {24'b0, got}, {24'b0, exp_q.pop_front()});
                    end
                end
                bytes_seen++;
            end
        end
    end

    // LED compare against the model whenever the bench declares them stable
    always @(negedge clk) begin
        if (chk_en) begin
            int unsigned sel;
            sel = {29'b0, sw2, sw1, sw0};
            check("led_nibble", {28'b0, led_nib}, (model_result >> (4 * sel)) & 32'hF);
            check("led4_idle", {31'b0, led4}, 32'd0);
        end
    end

    task automatic send_frame(input logic [7:0] data, input logic stop_bit);
        rx = 1'b0;
        repeat (BIT) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            repeat (BIT) @(posedge clk);
            #1;
        end
        rx = stop_bit;
        repeat (BIT) @(posedge clk);
        #1;
        rx = 1'b1;
    endtask

    task automatic push_expected(input logic [31:0] r);
        for (int i = 0; i < 4; i++) exp_q.push_back(8'(r >> (8 * i)));
    endtask

    task automatic wait_done();
        int unsigned budget = 80 * BIT;
        while (budget > 0 && (exp_q.size() != 0 || led4 !== 1'b0)) begin
            @(negedge clk);
            budget--;
        end
        check("reply_complete", {31'b0, budget > 0}, 32'd1);
    endtask

    task automatic do_request(input logic [7:0] n);
        logic [31:0] r;
        r = fib_model(n);
        chk_en = 1'b0;
        push_expected(r);
        send_frame(n, 1'b1);
        wait_done();
        model_result = r;
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic set_sw(input logic [2:0] v);
        chk_en = 1'b0;
        {sw2, sw1, sw0} = v;
        repeat (4) @(negedge clk);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [3:0] nib47 [8];
        int         base;
        int unsigned budget;

        nib47 = '{4'h1, 4'hE, 4'h4, 4'h2, 4'h9, 4'h1, 4'h1, 4'hB};

        // 1. reset with rx low and switches moving
        nRst = 1'b1; rx = 1'b0; {sw2, sw1, sw0} = 3'b000;
        #1 nRst = 1'b0;
        #5 {sw2, sw1, sw0} = 3'b101;
        #5 check("reset_tx", {31'b0, tx}, 32'd1);
        check("reset_leds", {27'b0, led4, led_nib}, 32'd0);
        {sw2, sw1, sw0} = 3'b010;
        #7 nRst = 1'b1;
        {sw2, sw1, sw0} = 3'b000;
        repeat (40 * BIT) @(negedge clk);
        check("rx_low_no_reply", bytes_seen, 0);
        check("rx_low_not_busy", {31'b0, led4}, 32'd0);
        check("rx_low_tx_idle", {31'b0, tx}, 32'd1);
        rx = 1'b1;
        repeat (4 * BIT) @(negedge clk);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);

        // pin the model with hand-computed values
        check("model_f10", fib_model(10), 32'h37);
        check("model_f47", fib_model(47), 32'hB11924E1);
        check("model_f48", fib_model(48), 32'hFFFF_FFFF);
        check("model_f1", fib_model(1), 32'h1);

        // 2. N = 10
        do_request(8'h0A);
        set_sw(3'b000);
        check("f10_sw0", {28'b0, led_nib}, 32'h7);
        set_sw(3'b001);
        check("f10_sw1", {28'b0, led_nib}, 32'h3);
        check("f10_led4", {31'b0, led4}, 32'd0);

        // 3. N = 47, sweep all nibbles
        do_request(8'h2F);
        for (int s = 0; s < 8; s++) begin
            set_sw(3'(s));
            check("f47_nibble", {28'b0, led_nib}, {28'b0, nib47[s]});
        end

        // 4. boundaries
        set_sw(3'b000);
        do_request(8'h00);
        do_request(8'h01);
        do_request(8'h30);
        check("sat_led", {28'b0, led_nib}, 32'hF);

        // 5a. stop bit low: discarded
        base = bytes_seen;
        chk_en = 1'b0;
        send_frame(8'h05, 1'b0);
        chk_en = 1'b1;
        repeat (60 * BIT) @(negedge clk);
        check("framing_no_reply", bytes_seen - base, 0);

        // 5b. second request during SEND is ignored
        base = bytes_seen;
        chk_en = 1'b0;
        push_expected(fib_model(12));
        send_frame(8'h0C, 1'b1);
        repeat (25 * BIT) @(posedge clk);
        #1;
        check("busy_during_send", {31'b0, led4}, 32'd1);
        send_frame(8'h03, 1'b1);
        wait_done();
        model_result = fib_model(12);
        chk_en = 1'b1;
        repeat (60 * BIT) @(negedge clk);
        check("exactly_four_bytes", bytes_seen - base, 4);

        // 6. reset during the second reply byte
        base = bytes_seen;
        chk_en = 1'b0;
        push_expected(fib_model(20));
        send_frame(8'h14, 1'b1);
        budget = 40 * BIT;
        while (budget > 0 && bytes_seen < base + 1) begin
            @(negedge clk);
            budget--;
        end
        check("first_byte_before_abort", {31'b0, budget > 0}, 32'd1);
        repeat (5 * BIT) @(posedge clk);
        #3;
        mon_discard = 1'b1;
        nRst = 1'b0;
        #1;
        check("abort_tx_high", {31'b0, tx}, 32'd1);
        check("abort_leds", {27'b0, led4, led_nib}, 32'd0);
        exp_q.delete();
        model_result = '0;
        repeat (3) @(posedge clk);
        #1 nRst = 1'b1;
        repeat (15 * BIT) @(negedge clk);
        mon_discard = 1'b0;
        check("abort_no_resume", {31'b0, tx}, 32'd1);
        do_request(8'h19);

        // randomized requests and switch settings
        for (int k = 0; k < 8; k++) begin
            do_request(8'($urandom_range(0, 55)));
            set_sw(3'($urandom_range(0, 7)));
        end

        chk_en = 1'b0;
        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
